// File: rtl/lockpick_host_driver.sv
// Host-side initiator for the lockpick byte protocol.
// Serialises a key pair into the game and returns its 16-byte reply.
module lockpick_host_driver #(
    parameter int BYTE_GAP     = 0,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [127:0] cmd_key_a,
    input  logic [127:0] cmd_key_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_msg,
    output logic [1:0]   rsp_status,
    output logic         rsp_timeout,
    output logic [1:0]   attempt_num,
    output logic         in_game,
    output logic         game_start,
    output logic         game_input_enable,
    output logic [7:0]   game_input_data,
    input  logic         game_output_valid,
    input  logic [7:0]   game_output_data,
    input  logic [1:0]   game_status
);

    typedef enum logic [2:0] {
        IDLE, START, SEND, GAP, WAIT_RSP, RECV, DONE
    } state_t;

    localparam logic [15:0] GAP_LAST = 16'(BYTE_GAP > 0 ? BYTE_GAP - 1 : 0);
    localparam logic [15:0] TO_LAST  = 16'(RESP_TIMEOUT - 1);

    state_t       state;
    logic [255:0] shift;
    logic [4:0]   byte_cnt;
    logic [3:0]   rx_idx;
    logic [15:0]  gap_cnt;
    logic [15:0]  timer;
    logic [1:0]   attempt_inc;

    assign attempt_inc       = (attempt_num == 2'd3) ? 2'd3 : attempt_num + 2'd1;
    assign game_start        = (state == START);
    assign game_input_enable = (state == SEND);
    assign game_input_data   = (state == SEND) ? shift[7:0] : 8'h00;
    assign rsp_valid         = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            shift       <= '0;
            byte_cnt    <= '0;
            rx_idx      <= '0;
            gap_cnt     <= '0;
            timer       <= '0;
            rsp_msg     <= '0;
            rsp_status  <= '0;
            rsp_timeout <= 1'b0;
            attempt_num <= '0;
            in_game     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready   <= 1'b0;
                        shift       <= {cmd_key_b, cmd_key_a};
                        byte_cnt    <= '0;
                        rsp_msg     <= '0;
                        rsp_status  <= '0;
                        rsp_timeout <= 1'b0;
                        if (!in_game) attempt_num <= '0;
                        state <= in_game ? SEND : START;
                    end
                end
                START: state <= SEND;
                SEND: begin
                    shift    <= shift >> 8;
                    byte_cnt <= byte_cnt + 5'd1;
                    if (byte_cnt == 5'd31) begin
                        state  <= WAIT_RSP;
                        timer  <= '0;
                        rx_idx <= '0;
                    end else if (BYTE_GAP > 0) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) state <= SEND;
                    else gap_cnt <= gap_cnt + 16'd1;
                end
                WAIT_RSP, RECV: begin
                    if (game_output_valid) begin
                        rsp_msg[{rx_idx, 3'b000} +: 8] <= game_output_data;
                        rx_idx <= rx_idx + 4'd1;
                        timer  <= '0;
                        state  <= RECV;
                        if (rx_idx == 4'd15) begin
                            rsp_status  <= game_status;
                            in_game     <= (game_status == 2'b01);
                            attempt_num <= attempt_inc;
                            state       <= DONE;
                        end
                    end else if (timer == TO_LAST) begin
                        // Partial message is kept so the host can inspect it.
                        rsp_timeout <= 1'b1;
                        rsp_status  <= 2'b00;
                        in_game     <= 1'b0;
                        attempt_num <= attempt_inc;
                        state       <= DONE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lockpick_host_driver.sv
// Bench for lockpick_host_driver: scoreboard of expected game
// traffic and responses, two instances (BYTE_GAP 0 and 2).
module tb_lockpick_host_driver;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         sel = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [127:0] key_a = '0, key_b = '0;
    logic         rsp_ready = 1'b0;
    logic         gov = 1'b0;
    logic [7:0]   god = '0;
    logic [1:0]   gst = '0;

    logic cv0, cv1;
    logic cr0, cr1, rv0, rv1, to0, to1, ig0, ig1;
    logic gs0, gs1, ge0, ge1;
    logic [127:0] rm0, rm1;
    logic [1:0]   rs0, rs1, an0, an1;
    logic [7:0]   gd0, gd1;

    assign cv0 = cmd_valid & ~sel;
    assign cv1 = cmd_valid & sel;

    lockpick_host_driver #(.BYTE_GAP(0), .RESP_TIMEOUT(TO)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cv0), .cmd_ready(cr0),
        .cmd_key_a(key_a), .cmd_key_b(key_b), .rsp_valid(rv0),
        .rsp_ready(rsp_ready), .rsp_msg(rm0), .rsp_status(rs0),
        .rsp_timeout(to0), .attempt_num(an0), .in_game(ig0),
        .game_start(gs0), .game_input_enable(ge0), .game_input_data(gd0),
        .game_output_valid(gov), .game_output_data(god), .game_status(gst)
    );

    lockpick_host_driver #(.BYTE_GAP(2), .RESP_TIMEOUT(TO)) dut2 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cv1), .cmd_ready(cr1),
        .cmd_key_a(key_a), .cmd_key_b(key_b), .rsp_valid(rv1),
        .rsp_ready(rsp_ready), .rsp_msg(rm1), .rsp_status(rs1),
        .rsp_timeout(to1), .attempt_num(an1), .in_game(ig1),
        .game_start(gs1), .game_input_enable(ge1), .game_input_data(gd1),
        .game_output_valid(gov), .game_output_data(god), .game_status(gst)
    );

    logic m_cr, m_rv, m_to, m_ig, m_gs, m_ge;
    logic [127:0] m_rm;
    logic [1:0]   m_rs, m_an;
    logic [7:0]   m_gd;
    assign m_cr = sel ? cr1 : cr0;
    assign m_rv = sel ? rv1 : rv0;
    assign m_to = sel ? to1 : to0;
    assign m_ig = sel ? ig1 : ig0;
    assign m_gs = sel ? gs1 : gs0;
    assign m_ge = sel ? ge1 : ge0;
    assign m_rm = sel ? rm1 : rm0;
    assign m_rs = sel ? rs1 : rs0;
    assign m_an = sel ? an1 : an0;
    assign m_gd = sel ? gd1 : gd0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    bit           m_in_game = 1'b0;
    int           m_attempt = 0;
    bit           exp_new = 1'b0;
    bit           start_pending = 1'b0;
    logic [7:0]   exp_q[$];
    int           sent = 0;
    int           log_b[32];
    int           acc_cyc = 0;
    int           last_en = 0;
    int           gap_n = 0;
    bit           armed = 1'b0;
    bit           first_rsp = 1'b0;
    logic [127:0] e_msg = '0;
    logic [1:0]   e_st = '0;
    bit           e_to = 1'b0;
    int           e_done = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_gs) begin
                chk("start_expected", 128'(start_pending), 128'(1));
                chk("start_latency", 128'(cyc - acc_cyc), 128'(0));
                start_pending = 1'b0;
            end
            if (m_ge) begin
                if (sent == 0) begin
                    chk("start_before_byte0", 128'(start_pending), 128'(0));
                    chk("byte0_latency", 128'(cyc - acc_cyc), 128'(exp_new));
                end else begin
                    chk("byte_spacing", 128'(cyc - last_en), 128'(gap_n + 1));
                end
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_byte: got %0h expected none", m_gd);
                end else begin
                    chk("byte_data", 128'(m_gd), 128'(exp_q.pop_front()));
                end
                if (sent < 32) log_b[sent] = int'(m_gd);
                sent++;
                last_en = cyc;
            end else begin
                chk("data_idle_zero", 128'(m_gd), 128'(0));
            end
            if (m_rv) begin
                chk("rsp_expected", 128'(armed), 128'(1));
                if (first_rsp) begin
                    chk("rsp_latency", 128'(cyc), 128'(e_done));
                    first_rsp = 1'b0;
                end
                chk("rsp_msg", m_rm, e_msg);
                chk("rsp_status", 128'(m_rs), 128'(e_st));
                chk("rsp_timeout", 128'(m_to), 128'(e_to));
                chk("attempt_num", 128'(m_an), 128'(m_attempt));
                chk("in_game", 128'(m_ig), 128'(m_in_game));
                chk("cmd_ready_busy", 128'(m_cr), 128'(0));
            end
        end
    end

    task automatic send_cmd(input logic [127:0] a, input logic [127:0] b);
        int n = 0;
        bit ok = 1'b0;
        key_a = a;
        key_b = b;
        cmd_valid = 1'b1;
        while (!ok && n < 100) begin
            ok = m_cr;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk("cmd_accepted", 128'(ok), 128'(1));
        exp_new = !m_in_game;
        if (exp_new) m_attempt = 0;
        start_pending = exp_new;
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(a[8*i +: 8]);
        for (int i = 0; i < 16; i++) exp_q.push_back(b[8*i +: 8]);
        sent = 0;
        acc_cyc = cyc;
    endtask

    task automatic respond(input logic [127:0] msg, input logic [1:0] st,
                           input bit silent, input int gap_at);
        int n = 0;
        while (sent < 32 && n < 400) begin
            tick();
            n++;
        end
        chk("all_bytes_sent", 128'(sent), 128'(32));
        e_to = silent;
        armed = 1'b1;
        first_rsp = 1'b1;
        if (silent) begin
            e_msg = '0;
            e_st = 2'b00;
            e_done = last_en + TO + 1;
            m_in_game = 1'b0;
            m_attempt = (m_attempt == 3) ? 3 : m_attempt + 1;
        end else begin
            e_msg = msg;
            e_st = st;
            for (int i = 0; i < 16; i++) begin
                if (i == gap_at) begin
                    gov = 1'b0;
                    repeat (5) tick();
                end
                gov = 1'b1;
                god = msg[8*i +: 8];
                gst = st;
                if (i == 15) begin
                    e_done = cyc + 1;
                    m_in_game = (st == 2'b01);
                    m_attempt = (m_attempt == 3) ? 3 : m_attempt + 1;
                end
                tick();
            end
            gov = 1'b0;
            god = '0;
            gst = '0;
        end
    endtask

    task automatic collect(input int hold);
        int n = 0;
        while (!m_rv && n < 200) begin
            tick();
            n++;
        end
        chk("rsp_valid_seen", 128'(m_rv), 128'(1));
        repeat (hold) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        armed = 1'b0;
        chk("rsp_valid_dropped", 128'(m_rv), 128'(0));
        chk("cmd_ready_after_rsp", 128'(m_cr), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ka, kb;
        ka = 128'h0F0E0D0C0B0A09080706050403020100;
        kb = 128'h1F1E1D1C1B1A19181716151413121110;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", 128'(m_cr), 128'(0));
        chk("reset_rsp_valid", 128'(m_rv), 128'(0));
        chk("reset_start", 128'(m_gs), 128'(0));
        chk("reset_enable", 128'(m_ge), 128'(0));
        chk("reset_in_game", 128'(m_ig), 128'(0));
        chk("reset_attempt", 128'(m_an), 128'(0));
        chk("reset_msg", m_rm, 128'(0));
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 128'(m_cr), 128'(0));
        tick();
        chk("ready_after_edge", 128'(m_cr), 128'(1));

        // Attempt 1: new game, status 01
        send_cmd(ka, kb);
        respond({8{16'hBAD0}}, 2'b01, 1'b0, -1);
        collect(0);
        for (int i = 0; i < 32; i++) chk("byte_order", 128'(log_b[i]), 128'(i));
        chk("a1_msg", m_rm, {8{16'hBAD0}});
        chk("a1_in_game", 128'(m_ig), 128'(1));
        chk("a1_attempt", 128'(m_an), 128'(1));

        // Attempt 2: continuing game, response with a valid gap
        send_cmd(128'h0123456789ABCDEFFEDCBA9876543210, 128'h55AA33CC_0F0F_F0F0_1234_5678_9ABC_DEF0);
        respond(128'h00112233445566778899AABBCCDDEEFF, 2'b01, 1'b0, 7);
        collect(0);
        chk("a2_attempt", 128'(m_an), 128'(2));

        // Attempt 3: lockout
        send_cmd(~ka, ~kb);
        respond({8{16'hDEAD}}, 2'b11, 1'b0, -1);
        collect(0);
        chk("a3_status", 128'(m_rs), 128'(2'b11));
        chk("a3_in_game", 128'(m_ig), 128'(0));
        chk("a3_attempt", 128'(m_an), 128'(3));

        // Attempt 4: new game again, win, slow consumer
        send_cmd(kb, ka);
        chk("a4_attempt_cleared", 128'(m_an), 128'(0));
        respond({8{16'hFACE}}, 2'b10, 1'b0, -1);
        collect(10);
        chk("a4_status", 128'(m_rs), 128'(2'b10));
        chk("a4_in_game", 128'(m_ig), 128'(0));

        // Attempt 5 opens a game, attempt 6 times out
        send_cmd(ka, ka);
        respond(128'hCAFEF00D_0000_1111_2222_3333_4444_5555, 2'b01, 1'b0, -1);
        collect(0);
        send_cmd(kb, kb);
        respond('0, 2'b00, 1'b1, -1);
        collect(0);
        chk("a6_timeout", 128'(m_to), 128'(1));
        chk("a6_status", 128'(m_rs), 128'(0));
        chk("a6_in_game", 128'(m_ig), 128'(0));
        chk("a6_attempt", 128'(m_an), 128'(2));

        // BYTE_GAP = 2 instance
        sel = 1'b1;
        gap_n = 2;
        m_in_game = 1'b0;
        m_attempt = 0;
        send_cmd(ka, kb);
        respond({8{16'h1357}}, 2'b01, 1'b0, -1);
        collect(0);
        chk("g1_in_game", 128'(m_ig), 128'(1));

        // Reset in the middle of the key transfer
        send_cmd(kb, ka);
        begin
            int n = 0;
            while (sent < 10 && n < 100) begin
                tick();
                n++;
            end
        end
        chk("g2_bytes_before_reset", 128'(sent), 128'(10));
        rst_n = 1'b0;
        #1;
        chk("rst_enable", 128'(m_ge), 128'(0));
        chk("rst_data", 128'(m_gd), 128'(0));
        chk("rst_start", 128'(m_gs), 128'(0));
        chk("rst_cmd_ready", 128'(m_cr), 128'(0));
        chk("rst_rsp_valid", 128'(m_rv), 128'(0));
        chk("rst_in_game", 128'(m_ig), 128'(0));
        chk("rst_attempt", 128'(m_an), 128'(0));
        m_in_game = 1'b0;
        m_attempt = 0;
        exp_q.delete();
        start_pending = 1'b0;
        armed = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rst_ready_after_edge", 128'(m_cr), 128'(1));

        send_cmd(ka, kb);
        respond({8{16'h2468}}, 2'b10, 1'b0, -1);
        collect(0);
        chk("g3_in_game", 128'(m_ig), 128'(0));
        chk("g3_attempt", 128'(m_an), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lockpick_host_driver.md
Name: lockpick_host_driver

Overview:
Host-side initiator for the lockpick game byte protocol. Accepts a 128-bit key pair per attempt on a valid/ready command port and serialises it as 32 input bytes (start pulse only when a new game is required). Collects the 16-byte result message and final status, and returns them on a valid/ready response port. Sits between a CPU/test controller and the game's start/input_enable/input_data and output_valid/output_data/status pins.

Parameters:
BYTE_GAP, 0, idle cycles (input_enable low) inserted between consecutive input bytes; 0 = back-to-back
RESP_TIMEOUT, 64, max cycles waited for each response byte before aborting; must be >= 8

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  driver can accept a command
cmd_key_a  in  128  key A; byte i = bits [8i+7:8i]
cmd_key_b  in  128  key B; same byte order
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_msg  out  128  captured result message; byte i stored at [8i+7:8i]
rsp_status  out  2  game status captured with the last byte (00 on timeout)
rsp_timeout  out  1  response aborted by timeout
attempt_num  out  2  attempts completed in the current game (saturates at 3)
in_game  out  1  a game is open (next command skips start)
game_start  out  1  to game start
game_input_enable  out  1  to game input_enable
game_input_data  out  8  to game input_data
game_output_valid  in  1  from game output_valid
game_output_data  in  8  from game output_data
game_status  in  2  from game status

Behaviour:
- Reset (async, immediate): FSM IDLE; all outputs 0 except cmd_ready, which is 1 from the first clock edge after reset release; keys, rsp_msg, counters, in_game, attempt_num cleared. A reset mid-transfer abandons the transfer with no response.
- All game_* and rsp_* outputs are decoded from registers only; no combinational path from any input.
- FSM states: IDLE, START, SEND, GAP, WAIT_RSP, RECV, DONE.
- IDLE: cmd_ready=1. On cmd_valid, load 256-bit shift register {key_b,key_a}, clear byte_cnt, rsp_msg, rsp_timeout. Next state is SEND if in_game=1, otherwise START. If in_game=0, attempt_num also clears to 0.
- START: game_start=1 for exactly one cycle. Next state is SEND.
- SEND: game_input_enable=1 and game_input_data=shift[7:0] for one cycle. Then shift right by 8 and increment byte_cnt.
  - byte_cnt==31 -> WAIT_RSP.
  - else BYTE_GAP>0 -> GAP.
  - else stay in SEND.
  - Order: A byte0..15, then B byte0..15, with no start between A and B.
- GAP: enable=0 and data=00 for BYTE_GAP cycles, then SEND. game_input_data is 00 whenever enable=0.
- WAIT_RSP/RECV: the timer clears on entry and on each captured byte, and increments otherwise.
  - Each cycle game_output_valid=1 captures game_output_data into rsp_msg byte rx_idx, then rx_idx++. The first capture moves WAIT_RSP to RECV.
  - On capturing byte 15, latch game_status into rsp_status and go to DONE.
  - Timer reaching RESP_TIMEOUT -> DONE with rsp_timeout=1, rsp_status=00, and any partial rsp_msg retained.
  - A valid gap mid-response is tolerated up to the timeout.
- game_output_valid is ignored in IDLE, START, SEND, GAP and DONE.
- DONE: rsp_valid=1, with rsp_* held stable until rsp_ready. On the entry cycle, attempt_num increments (saturating at 3) and in_game is updated:
  - 1 if status 01 and no timeout.
  - 0 if status 10 (win), 11 (lockout), 00, or timeout.
- DONE with rsp_ready=1 -> IDLE next cycle. cmd_ready rises that cycle, so there is a 1-cycle bubble minimum between a response handshake and the next command acceptance.
- cmd_valid outside IDLE is ignored; command fields are sampled only on acceptance.
- Latency, BYTE_GAP=0, new game: start at cycle 1 after acceptance; bytes at cycles 2..33; rsp_valid one cycle after byte 15 is captured.

Test Plan:
- Fresh command, A=0x0F0E..0100, B=0x1F1E..1110, BYTE_GAP=0 -> one start pulse, then 32 consecutive enable cycles with data 00,01..0F,10..1F; no start between A and B.
- Game model answers {8{16'hBAD0}}, status 01 -> rsp_msg=BAD0 pattern, rsp_status=01, in_game=1, attempt_num=1; next command produces no start pulse.
- Third attempt answers {8{16'hDEAD}}, status 11 -> rsp_status=11, in_game=0, attempt_num=3; next command pulses start and attempt_num restarts from 0.
- Model answers {8{16'hFACE}}, status 10 -> rsp_status=10, in_game=0; rsp held stable while rsp_ready is low for 10 cycles.
- Model silent after byte 31 (RESP_TIMEOUT=64) -> rsp_valid after 64 cycles with rsp_timeout=1, rsp_status=00, in_game=0.
- BYTE_GAP=2 -> enable high 1 of every 3 cycles, 32 pulses. Reset asserted at byte 10 -> all outputs 0 immediately, in_game=0, and the next command pulses start.
